// File: rtl/sha256_iter_if.sv
// Job/result bundle between the work distributor and the SHA-256 iterative core.
// Master drives the job fields and start; slave returns busy, done and the hash.
interface sha256_iter_if;
    logic         start;
    logic [511:0] data;
    logic [255:0] midstate;
    logic         midstate_en;
    logic         dbl;
    logic         busy;
    logic         done;
    logic [255:0] hash;

    modport master (output start, data, midstate, midstate_en, dbl,
                    input  busy, done, hash);
    modport slave  (input  start, data, midstate, midstate_en, dbl,
                    output busy, done, hash);
endinterface

// File: rtl/sha256_iter_core.sv
// Iterative SHA-256 block compression, UNROLL rounds per clock, optional SHA256d second pass.
// Latency: 64/UNROLL+2 cycles single pass, 2*(64/UNROLL+1)+1 double pass, accept edge to done seen.
// Backpressure: none; start is taken only while idle (including the done cycle), otherwise dropped.
module sha256_iter_core #(
    parameter int UNROLL = 1,
    parameter bit DBL_EN = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    sha256_iter_if.slave io
);

    if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4 && UNROLL != 8) begin : g_bad_unroll
        $error("sha256_iter_core: UNROLL must be 1, 2, 4 or 8");
    end

    localparam logic [255:0] H0 = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                   32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

    localparam logic [0:63][31:0] K = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [5:0] LAST_CNT = 6'(64 - UNROLL);

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [255:0] round_fn(input logic [255:0] s, input logic [31:0] k,
                                              input logic [31:0] wt);
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        {a, b, c, d, e, f, g, h} = s;
        t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + k + wt;
        t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
        return {t1 + t2, a, b, c, d + t1, e, f, g};
    endfunction

    // Word i of the buffer is W[cnt+i]; W0 sits in the top bits of the block.
    function automatic logic [15:0][31:0] load_w(input logic [511:0] blk);
        logic [15:0][31:0] w;
        for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
        return w;
    endfunction

    typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;

    state_t            state, state_nxt;
    logic [5:0]        cnt;
    logic [15:0][31:0] w_q, w_shift;
    logic [255:0]      st_q, ff_q, st_rnd, result, seed, hash_q;
    logic [511:0]      pad_blk;
    logic              dbl_q, done_q;

    assign seed    = io.midstate_en ? io.midstate : H0;
    assign pad_blk = {result, 32'h80000000, 192'h0, 32'h00000100};

    // Extend the schedule by UNROLL words, then chain UNROLL rounds combinationally.
    always_comb begin : p_round
        logic [16+UNROLL-1:0][31:0] wx;
        logic [255:0]               cur;
        wx        = '0;
        wx[15:0]  = w_q;
        for (int j = 0; j < UNROLL; j++)
            wx[16+j] = ssig1(wx[14+j]) + wx[9+j] + ssig0(wx[1+j]) + wx[j];
        cur = st_q;
        for (int j = 0; j < UNROLL; j++)
            cur = round_fn(cur, K[cnt + 6'(j)], wx[j]);
        st_rnd  = cur;
        w_shift = wx[UNROLL +: 16];
    end

    always_comb begin
        result = '0;
        for (int i = 0; i < 8; i++)
            result[32*i +: 32] = ff_q[32*i +: 32] + st_q[32*i +: 32];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (io.start) state_nxt = ROUND;
            ROUND:   if (cnt == LAST_CNT) state_nxt = FINAL;
            FINAL:   state_nxt = dbl_q ? ROUND : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt    <= '0;
            w_q    <= '0;
            st_q   <= '0;
            ff_q   <= '0;
            dbl_q  <= 1'b0;
            done_q <= 1'b0;
            hash_q <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: if (io.start) begin
                    w_q   <= load_w(io.data);
                    st_q  <= seed;
                    ff_q  <= seed;
                    dbl_q <= DBL_EN && io.dbl;
                    cnt   <= '0;
                end
                ROUND: begin
                    st_q <= st_rnd;
                    w_q  <= w_shift;
                    cnt  <= cnt + 6'(UNROLL);
                end
                FINAL: if (dbl_q) begin
                    // Second pass hashes the padded 256-bit digest from H0.
                    w_q   <= load_w(pad_blk);
                    st_q  <= H0;
                    ff_q  <= H0;
                    cnt   <= '0;
                    dbl_q <= 1'b0;
                end else begin
                    hash_q <= result;
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign io.busy = (state != IDLE);
    assign io.done = done_q;
    assign io.hash = hash_q;

endmodule

// File: tb/tb_sha256_iter_core.sv
// Directed + random bench for sha256_iter_core at UNROLL 1, 4 (both SHA256d-capable) and 8 (no SHA256d).
// Expected hashes come from known-answer constants or an independent software compression model.
module tb_sha256_iter_core;

    localparam logic [255:0] H0 = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                   32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    localparam logic [511:0] ABC_BLK   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'h0};
    localparam logic [255:0] ABC_H   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] EMPTY_H = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] DBL_H   = 256'h4f8b42c22dd3729b519ba6f68d2da7cc5b2d606d05daed5ad5128cc03e6c6358;

    localparam logic [31:0] KT [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [511:0] data_r = '0;
    logic [255:0] mid_r = '0;
    logic         men_r = 1'b0;
    logic         dbl_r = 1'b0;
    int           checks = 0;
    int           failures = 0;
    int           cyc = 0;
    int           acc_cyc = 0;
    logic [255:0] sb [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sha256_iter_if if1 ();
    sha256_iter_if if4 ();
    sha256_iter_if if8 ();

    assign if1.data = data_r;  assign if1.midstate = mid_r;  assign if1.midstate_en = men_r;  assign if1.dbl = dbl_r;
    assign if4.data = data_r;  assign if4.midstate = mid_r;  assign if4.midstate_en = men_r;  assign if4.dbl = dbl_r;
    assign if8.data = data_r;  assign if8.midstate = mid_r;  assign if8.midstate_en = men_r;  assign if8.dbl = dbl_r;

    sha256_iter_core #(.UNROLL(1), .DBL_EN(1'b1)) u_dut1 (.clk(clk), .reset(reset), .io(if1));
    sha256_iter_core #(.UNROLL(4), .DBL_EN(1'b1)) u_dut4 (.clk(clk), .reset(reset), .io(if4));
    sha256_iter_core #(.UNROLL(8), .DBL_EN(1'b0)) u_dut8 (.clk(clk), .reset(reset), .io(if8));

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sw_compress(input logic [255:0] seed, input logic [511:0] blk);
        logic [31:0]  w [64];
        logic [31:0]  v [8];
        logic [31:0]  t1, t2;
        logic [255:0] out;
        for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++)
            w[t] = (rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                 + (rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
        for (int i = 0; i < 8; i++) v[i] = seed[255 - 32*i -: 32];
        for (int t = 0; t < 64; t++) begin
            t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
            t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
            v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) out[255 - 32*i -: 32] = seed[255 - 32*i -: 32] + v[i];
        return out;
    endfunction

    function automatic logic [255:0] sw_job(input logic [511:0] blk, input logic [255:0] mid,
                                            input logic men, input logic d, input logic d_en);
        logic [255:0] r;
        r = sw_compress(men ? mid : H0, blk);
        if (d && d_en) r = sw_compress(H0, {r, 32'h80000000, 192'h0, 32'h00000100});
        return r;
    endfunction

    function automatic int unroll_of(input int sel);
        return (sel == 0) ? 1 : (sel == 1) ? 4 : 8;
    endfunction

    function automatic logic dbl_en_of(input int sel);
        return sel != 2;
    endfunction

    function automatic int lat_of(input int sel, input logic d);
        return (d && dbl_en_of(sel)) ? 2 * (64 / unroll_of(sel) + 1) + 1 : 64 / unroll_of(sel) + 2;
    endfunction

    function automatic logic get_busy(input int sel);
        return (sel == 0) ? if1.busy : (sel == 1) ? if4.busy : if8.busy;
    endfunction

    function automatic logic get_done(input int sel);
        return (sel == 0) ? if1.done : (sel == 1) ? if4.done : if8.done;
    endfunction

    function automatic logic [255:0] get_hash(input int sel);
        return (sel == 0) ? if1.hash : (sel == 1) ? if4.hash : if8.hash;
    endfunction

    task automatic set_start(input int sel, input logic v);
        if (sel == 0) if1.start = v;
        else if (sel == 1) if4.start = v;
        else if8.start = v;
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one job for a single accepting edge, then scramble the inputs behind it.
    task automatic launch(input int sel, input logic [511:0] blk, input logic [255:0] mid,
                          input logic men, input logic d, input logic [255:0] exp, input string tag);
        data_r = blk; mid_r = mid; men_r = men; dbl_r = d;
        set_start(sel, 1'b1);
        @(posedge clk); #1;
        set_start(sel, 1'b0);
        acc_cyc = cyc;
        sb.push_back(exp);
        check({tag, "_busy"}, 256'(get_busy(sel)), 256'(1));
        data_r = ~blk; mid_r = ~mid; men_r = ~men; dbl_r = ~d;
    endtask

    task automatic wait_done(input int sel, input int exp_lat, input string tag);
        logic [255:0] exp_h;
        logic         seen;
        seen = 1'b0;
        while (!seen && (cyc - acc_cyc) < 400) begin
            @(posedge clk); #1;
            seen = get_done(sel);
        end
        check({tag, "_done_seen"}, 256'(seen), 256'(1));
        exp_h = (sb.size() > 0) ? sb.pop_front() : '0;
        if (seen) begin
            check({tag, "_latency"}, 256'(cyc - acc_cyc + 1), 256'(exp_lat));
            check({tag, "_busy_at_done"}, 256'(get_busy(sel)), 256'(0));
            check({tag, "_hash"}, get_hash(sel), exp_h);
        end
    endtask

    initial begin
        logic [511:0] blk;
        logic [255:0] mid;
        logic         men, d;
        if1.start = 1'b0; if4.start = 1'b0; if8.start = 1'b0;

        #12;
        for (int s = 0; s < 3; s++) begin
            check("reset_busy", 256'(get_busy(s)), 256'(0));
            check("reset_done", 256'(get_done(s)), 256'(0));
            check("reset_hash", get_hash(s), 256'(0));
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        launch(0, ABC_BLK, 256'h0, 1'b0, 1'b0, ABC_H, "abc_u1");
        wait_done(0, 66, "abc_u1");
        @(posedge clk); #1;
        check("abc_u1_done_width", 256'(get_done(0)), 256'(0));

        launch(0, ABC_BLK, H0, 1'b1, 1'b0, ABC_H, "mid_h0_u1");
        wait_done(0, 66, "mid_h0_u1");

        launch(0, ABC_BLK, 256'h0, 1'b0, 1'b1, DBL_H, "dbl_u1");
        wait_done(0, 131, "dbl_u1");

        launch(1, EMPTY_BLK, 256'h0, 1'b0, 1'b0, EMPTY_H, "empty_u4");
        wait_done(1, 18, "empty_u4");

        launch(1, ABC_BLK, 256'h0, 1'b0, 1'b1, DBL_H, "dbl_u4");
        wait_done(1, 35, "dbl_u4");

        launch(2, ABC_BLK, 256'h0, 1'b0, 1'b1, ABC_H, "dbl_ignored_u8");
        wait_done(2, 10, "dbl_ignored_u8");

        // A start pulse mid-job must not disturb or queue behind the running job.
        launch(0, ABC_BLK, 256'h0, 1'b0, 1'b0, ABC_H, "busy_ign");
        repeat (10) @(posedge clk);
        #1;
        data_r = EMPTY_BLK; men_r = 1'b0; dbl_r = 1'b0;
        if1.start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        if1.start = 1'b0;
        wait_done(0, 66, "busy_ign");
        repeat (70) @(posedge clk);
        #1;
        check("busy_ign_no_second_job", 256'(get_busy(0)), 256'(0));
        check("busy_ign_hash_held", get_hash(0), ABC_H);

        // Start held high: a new job is taken in every done cycle.
        data_r = EMPTY_BLK; mid_r = '0; men_r = 1'b0; dbl_r = 1'b0;
        if4.start = 1'b1;
        @(posedge clk); #1;
        acc_cyc = cyc;
        sb.push_back(EMPTY_H);
        data_r = ABC_BLK;
        sb.push_back(ABC_H);
        wait_done(1, 18, "b2b_1");
        @(posedge clk); #1;
        acc_cyc = cyc;
        check("b2b_1_done_width", 256'(get_done(1)), 256'(0));
        check("b2b_1_rearm_busy", 256'(get_busy(1)), 256'(1));
        data_r = EMPTY_BLK;
        sb.push_back(EMPTY_H);
        wait_done(1, 18, "b2b_2");
        @(posedge clk); #1;
        acc_cyc = cyc;
        check("b2b_2_done_width", 256'(get_done(1)), 256'(0));
        if4.start = 1'b0;
        wait_done(1, 18, "b2b_3");
        @(posedge clk); #1;
        check("b2b_3_idle", 256'(get_busy(1)), 256'(0));

        for (int s = 0; s < 3; s++) begin
            for (int n = 0; n < ((s == 0) ? 3 : 6); n++) begin
                for (int i = 0; i < 16; i++) blk[32*i +: 32] = $urandom();
                for (int i = 0; i < 8; i++) mid[32*i +: 32] = $urandom();
                men = 1'($urandom_range(1));
                d   = 1'($urandom_range(1));
                launch(s, blk, mid, men, d, sw_job(blk, mid, men, d, dbl_en_of(s)), "rand");
                wait_done(s, lat_of(s, d), "rand");
            end
        end

        // Reset around round 30 aborts the job and clears the result.
        launch(0, ABC_BLK, 256'h0, 1'b0, 1'b0, ABC_H, "abort");
        repeat (30) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("abort_busy", 256'(get_busy(0)), 256'(0));
        check("abort_done", 256'(get_done(0)), 256'(0));
        check("abort_hash", get_hash(0), 256'(0));
        sb.delete();
        @(posedge clk); #1;
        check("abort_hold_done", 256'(get_done(0)), 256'(0));
        reset = 1'b1;
        @(posedge clk); #1;
        launch(0, ABC_BLK, 256'h0, 1'b0, 1'b0, ABC_H, "post_reset");
        wait_done(0, 66, "post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
